// File: rtl/read_control.sv
// Read-side FIFO controller: issues memory reads, tracks the read pointer and
// presents returned words through a 2-entry first-word-fall-through buffer.
`ifndef FIFO_DEPTH
`define FIFO_DEPTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module read_control #(
  parameter int unsigned MEM_DEPTH  = `FIFO_DEPTH,
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_empty,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  rd_ready,
  output logic                  rd_en,
  output logic [ADDR_WIDTH:0]   rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [1:0]            rd_buf_cnt
);

  localparam int unsigned PTR_WIDTH = ADDR_WIDTH + 1;

  if (MEM_DEPTH < 2 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_depth_check
    $error("read_control: MEM_DEPTH must be a power of two, 2 or more");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  buf_state_t            state, state_n;
  logic [DATA_WIDTH-1:0] head, head_n;
  logic [DATA_WIDTH-1:0] tail, tail_n;
  logic                  valid_q;
  logic                  inflight;
  logic                  pop;
  logic [2:0]            credit_used;

  assign pop         = valid_q & rd_ready;
  // Words already held or on their way, net of the word leaving this cycle.
  assign credit_used = 3'(state) + 3'(inflight) - 3'(pop);
  assign rd_en       = ~reset & ~rd_empty & (credit_used < 3'd2);

  assign rd_data    = head;
  assign rd_valid   = valid_q;
  assign rd_buf_cnt = state;

  // Pointer, in-flight tracking and output buffer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr  <= '0;
      inflight <= 1'b0;
      state    <= EMPTY;
      head     <= '0;
      tail     <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_addr <= rd_addr + PTR_WIDTH'(1);
      end
      inflight <= rd_en;
      state    <= state_n;
      head     <= head_n;
      tail     <= tail_n;
      valid_q  <= (state_n != EMPTY);
    end
  end

  // Output buffer next state: push is the returning memory word.
  always_comb begin
    state_n = state;
    head_n  = head;
    tail_n  = tail;
    unique case (state)
      EMPTY: begin
        if (inflight) begin
          state_n = ONE;
          head_n  = mem_rd_data;
        end
      end
      ONE: begin
        if (inflight && pop) begin
          head_n = mem_rd_data;
        end else if (inflight) begin
          state_n = TWO;
          tail_n  = mem_rd_data;
        end else if (pop) begin
          state_n = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_n = tail;
          if (inflight) begin
            tail_n = mem_rd_data;
          end else begin
            state_n = ONE;
          end
        end
      end
      default: begin
        state_n = EMPTY;
      end
    endcase
  end

  // Credit accounting must never let a word arrive at a full, stalled buffer.
  assert property (@(posedge clk) disable iff (reset)
                   !(state == TWO && inflight && !pop))
    else $error("read_control: push into full output buffer");

endmodule
